// File: rtl/uart_top_if.sv
// Byte-level handshake between a UART loopback block and its user:
// transmit request/data in, serial line and received byte out.
interface uart_top_if;
   logic       tx_start;
   logic [7:0] data_in;
   logic       tx;
   logic [7:0] data_out;
   logic       rx_done;

   modport master (output tx_start, data_in, input tx, data_out, rx_done);
   modport slave  (input tx_start, data_in, output tx, data_out, rx_done);
endinterface

// File: rtl/uart_top.sv
// 8N1 UART TX/RX pair with tx looped back into rx through a 2-flop synchronizer.
// rx_done fires exactly 9*CLKS_PER_BIT + CLKS_PER_BIT/2 + 4 cycles after the accept cycle.
//
// state   | meaning (TX)                     | meaning (RX)
// S_IDLE  | line high, waiting for tx_start  | waiting for a low on the synced line
// S_START | driving start bit (0)            | half-bit wait, then confirm start bit
// S_DATA  | driving data bits LSB first      | sampling 8 data bits at bit centres
// S_STOP  | driving stop bit (1)             | sampling stop bit, reporting good frames
module uart_top #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   uart_top_if.slave  bus
);
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e        tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          tx_q, tx_d;

   state_e        rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [1:0]    sync_q, sync_d;
   logic [7:0]    data_out_q, data_out_d;
   logic          rx_done_q, rx_done_d;
   logic          rx_line;

   assign rx_line      = sync_q[1];
   assign bus.tx       = tx_q;
   assign bus.data_out = data_out_q;
   assign bus.rx_done  = rx_done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_q       <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         sync_q     <= 2'b11;
         data_out_q <= '0;
         rx_done_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_q       <= tx_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         sync_q     <= sync_d;
         data_out_q <= data_out_d;
         rx_done_q  <= rx_done_d;
      end
   end

   // tx_d is the value for the next cycle, so the line changes exactly on state edges
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_d       = tx_q;
      case (tx_state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (bus.tx_start) begin
               tx_shift_d = bus.data_in;
               tx_cnt_d   = BIT_LAST;
               tx_d       = 1'b0;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d   = BIT_LAST;
               tx_bit_d   = '0;
               tx_d       = tx_shift_q[0];
               tx_state_d = S_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q - CW'(1);
            end
         end
         S_DATA: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d = BIT_LAST;
               if (tx_bit_q == 3'd7) begin
                  tx_d       = 1'b1;
                  tx_state_d = S_STOP;
               end else begin
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_d       = tx_shift_q[1];
                  tx_bit_d   = tx_bit_q + 3'd1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q - CW'(1);
            end
         end
         S_STOP: begin
            if (tx_cnt_q == '0) tx_state_d = S_IDLE;
            else                tx_cnt_d   = tx_cnt_q - CW'(1);
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sync_d     = {sync_q[0], tx_q};
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      data_out_d = data_out_q;
      rx_done_d  = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            if (!rx_line) begin
               rx_cnt_d   = HALF_LAST;
               rx_state_d = S_START;
            end
         end
         S_START: begin
            if (rx_cnt_q == '0) begin
               if (!rx_line) begin
                  rx_cnt_d   = BIT_LAST;
                  rx_bit_d   = '0;
                  rx_state_d = S_DATA;
               end else begin
                  rx_state_d = S_IDLE;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CW'(1);
            end
         end
         S_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_cnt_d   = BIT_LAST;
               rx_shift_d = {rx_line, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else begin
               rx_cnt_d = rx_cnt_q - CW'(1);
            end
         end
         S_STOP: begin
            if (rx_cnt_q == '0) begin
               rx_state_d = S_IDLE;
               // a low stop bit is a framing error: drop the byte silently
               if (rx_line) begin
                  data_out_d = rx_shift_q;
                  rx_done_d  = 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CW'(1);
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_top.sv
// Directed loopback bench for uart_top: checks serial waveform, rx_done latency,
// received bytes, busy-ignore, back-to-back frames and mid-frame reset.
module tb_uart_top;
   localparam int CPB   = 16;
   localparam int LAT   = 9*CPB + CPB/2 + 4;
   localparam int FRAME = 10*CPB + 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;

   int         rx_cyc_q[$];
   logic [7:0] rx_dat_q[$];
   logic       prev_done = 1'b0;

   uart_top_if bus ();

   uart_top #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (bus.rx_done === 1'b1) begin
         rx_cyc_q.push_back(cyc);
         rx_dat_q.push_back(bus.data_out);
         check("rx_done_gap", {31'd0, prev_done}, 32'd0);
      end
      prev_done = bus.rx_done;
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic clear_rx();
      rx_cyc_q.delete();
      rx_dat_q.delete();
   endtask

   task automatic start_frame(input logic [7:0] d, output int k);
      bus.data_in  = d;
      bus.tx_start = 1'b1;
      k = cyc;
      @(negedge clk);
      bus.tx_start = 1'b0;
      bus.data_in  = ~d;
   endtask

   task automatic check_frame_tx(input string tag, input logic [7:0] d, input int k);
      logic exp_bit;
      for (int b = 0; b < 10; b++) begin
         wait_until(k + 1 + b*CPB + CPB/2);
         if (b == 0)      exp_bit = 1'b0;
         else if (b == 9) exp_bit = 1'b1;
         else             exp_bit = d[b-1];
         check($sformatf("%s_bit%0d", tag, b), {31'd0, bus.tx}, {31'd0, exp_bit});
      end
   endtask

   task automatic check_pulse(input string tag, input int idx, input int k, input logic [7:0] d);
      if (idx < rx_cyc_q.size()) begin
         check({tag, "_lat"}, rx_cyc_q[idx] - k, LAT);
         check({tag, "_data"}, {24'd0, rx_dat_q[idx]}, {24'd0, d});
      end else begin
         check({tag, "_missing"}, rx_cyc_q.size(), idx + 1);
      end
   endtask

   initial begin
      int k, k2;
      int bad_tx, bad_do, bad_rd;
      logic [7:0] seq [3];
      int ks [3];
      seq = '{8'h00, 8'hFF, 8'h3C};

      bus.tx_start = 1'b0;
      bus.data_in  = 8'h00;
      reset        = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      bad_tx = 0; bad_do = 0; bad_rd = 0;
      repeat (5*CPB) begin
         @(negedge clk);
         if (bus.tx !== 1'b1)        bad_tx++;
         if (bus.data_out !== 8'h00) bad_do++;
         if (bus.rx_done !== 1'b0)   bad_rd++;
      end
      check("idle_tx_bad", bad_tx, 0);
      check("idle_dout_bad", bad_do, 0);
      check("idle_rxdone_bad", bad_rd, 0);

      clear_rx();
      start_frame(8'hA5, k);
      check_frame_tx("a5_tx", 8'hA5, k);
      wait_until(k + LAT + 10);
      check("a5_count", rx_cyc_q.size(), 1);
      check_pulse("a5", 0, k, 8'hA5);
      check("a5_dout_hold", {24'd0, bus.data_out}, 32'hA5);

      clear_rx();
      for (int i = 0; i < 3; i++) begin
         start_frame(seq[i], ks[i]);
         wait_until(ks[i] + FRAME + 20);
      end
      check("seq_count", rx_cyc_q.size(), 3);
      for (int i = 0; i < 3; i++) check_pulse($sformatf("seq%0d", i), i, ks[i], seq[i]);

      clear_rx();
      start_frame(8'h5A, k);
      wait_until(k + 50);
      bus.data_in  = 8'h12;
      bus.tx_start = 1'b1;
      @(negedge clk);
      bus.tx_start = 1'b0;
      wait_until(k + FRAME + LAT + 20);
      check("busy_count", rx_cyc_q.size(), 1);
      check_pulse("busy", 0, k, 8'h5A);

      clear_rx();
      bus.data_in  = 8'hC3;
      bus.tx_start = 1'b1;
      k = cyc;
      wait_until(k + 1);
      check("hold_start1", {31'd0, bus.tx}, 0);
      wait_until(k + FRAME - 1);
      check("hold_stop1", {31'd0, bus.tx}, 1);
      wait_until(k + FRAME);
      check("hold_gap", {31'd0, bus.tx}, 1);
      wait_until(k + FRAME + 1);
      check("hold_start2", {31'd0, bus.tx}, 0);
      wait_until(k + FRAME + 9);
      bus.tx_start = 1'b0;
      wait_until(k + FRAME + LAT + 10);
      check("hold_count", rx_cyc_q.size(), 2);
      check_pulse("hold0", 0, k, 8'hC3);
      check_pulse("hold1", 1, k + FRAME, 8'hC3);

      clear_rx();
      start_frame(8'h81, k);
      wait_until(k + 88);
      check("rst_bit4_low", {31'd0, bus.tx}, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_tx_high", {31'd0, bus.tx}, 1);
      check("rst_rxdone", {31'd0, bus.rx_done}, 0);
      check("rst_dout", {24'd0, bus.data_out}, 0);
      wait_until(k + FRAME + LAT + 20);
      check("rst_count", rx_cyc_q.size(), 0);
      check("rst_dout_hold", {24'd0, bus.data_out}, 0);

      clear_rx();
      start_frame(8'h7E, k2);
      check_frame_tx("7e_tx", 8'h7E, k2);
      wait_until(k2 + LAT + 10);
      check("7e_count", rx_cyc_q.size(), 1);
      check_pulse("7e", 0, k2, 8'h7E);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
